// File: rtl/deserializer_param.sv
// UART-RX deserializer: assembles strobed, oversampled bits into a word of runtime length,
// LSB- or MSB-first, with a frame-done pulse, running parity and a hold state.
module deserializer_param #(
    parameter int DATA_WIDTH      = 8,
    parameter int PRESCALER_WIDTH = 6,
    parameter bit MSB_FIRST       = 1'b0
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               deser_en,
    input  logic                               sampled_bit,
    input  logic [PRESCALER_WIDTH-1:0]         edge_count,
    input  logic [PRESCALER_WIDTH-1:0]         prescaler,
    input  logic [$clog2(DATA_WIDTH+1)-1:0]    data_len,
    output logic [DATA_WIDTH-1:0]              parallel_data,
    output logic                               data_done,
    output logic                               par_calc,
    output logic                               busy
);

    localparam int LEN_W = $clog2(DATA_WIDTH + 1);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t                     state, state_nxt;
    logic [LEN_W-1:0]           bit_cnt, len, len_in, wr_idx;
    logic [PRESCALER_WIDTH-1:0] presc_m1;
    logic [DATA_WIDTH-1:0]      data_wr;
    logic                       strobe, last_bit;

    // prescaler 0/1 would make presc_m1 match edge_count trivially, so it is excluded
    assign presc_m1 = prescaler - PRESCALER_WIDTH'(1);
    assign strobe   = deser_en && (prescaler > PRESCALER_WIDTH'(1)) && (edge_count == presc_m1);
    assign len_in   = ((data_len == '0) || (data_len > MAX_LEN)) ? MAX_LEN : data_len;
    assign last_bit = (bit_cnt == len - LEN_W'(1));

    always_comb begin
        if (state == IDLE)
            wr_idx = MSB_FIRST ? len_in - LEN_W'(1) : '0;
        else
            wr_idx = MSB_FIRST ? len - LEN_W'(1) - bit_cnt : bit_cnt;
    end

    // A new frame starts from an all-zero word so bits above len-1 never carry old data
    always_comb begin
        data_wr = (state == IDLE) ? '0 : parallel_data;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            if (LEN_W'(i) == wr_idx)
                data_wr[i] = sampled_bit;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!deser_en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (strobe) state_nxt = (len_in == LEN_W'(1)) ? HOLD : SHIFT;
                SHIFT:   if (strobe && last_bit) state_nxt = HOLD;
                HOLD:    state_nxt = HOLD;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state == SHIFT);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bit_cnt       <= '0;
            len           <= '0;
            parallel_data <= '0;
            data_done     <= 1'b0;
            par_calc      <= 1'b0;
        end else begin
            data_done <= 1'b0;
            if (!deser_en) begin
                bit_cnt <= '0;
            end else if (strobe) begin
                case (state)
                    IDLE: begin
                        len           <= len_in;
                        parallel_data <= data_wr;
                        par_calc      <= sampled_bit;
                        bit_cnt       <= LEN_W'(1);
                        data_done     <= (len_in == LEN_W'(1));
                    end
                    SHIFT: begin
                        parallel_data <= data_wr;
                        par_calc      <= par_calc ^ sampled_bit;
                        bit_cnt       <= bit_cnt + LEN_W'(1);
                        data_done     <= last_bit;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_deserializer_param.sv
// Scoreboard bench: an LSB-first and an MSB-first instance share one stimulus stream;
// expected words are queued per frame and popped by a monitor on each data_done.
module tb_deserializer_param;

    logic       CLK = 1'b0;
    logic       RST;
    logic       deser_en;
    logic       sampled_bit;
    logic [5:0] edge_count;
    logic [5:0] prescaler;
    logic [3:0] data_len;

    logic [7:0] pd_l, pd_m;
    logic       done_l, done_m, par_l, par_m, busy_l, busy_m;

    int checks = 0;
    int errors = 0;

    logic [8:0] q_l[$];
    logic [8:0] q_m[$];

    always #5 CLK = ~CLK;

    deserializer_param #(.DATA_WIDTH(8), .PRESCALER_WIDTH(6), .MSB_FIRST(1'b0)) u_lsb (
        .CLK(CLK), .RST(RST), .deser_en(deser_en), .sampled_bit(sampled_bit),
        .edge_count(edge_count), .prescaler(prescaler), .data_len(data_len),
        .parallel_data(pd_l), .data_done(done_l), .par_calc(par_l), .busy(busy_l)
    );

    deserializer_param #(.DATA_WIDTH(8), .PRESCALER_WIDTH(6), .MSB_FIRST(1'b1)) u_msb (
        .CLK(CLK), .RST(RST), .deser_en(deser_en), .sampled_bit(sampled_bit),
        .edge_count(edge_count), .prescaler(prescaler), .data_len(data_len),
        .parallel_data(pd_m), .data_done(done_m), .par_calc(par_m), .busy(busy_m)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (done_l) begin
            check("lsb_done_expected", 32'(q_l.size() != 0), 32'd1);
            if (q_l.size() != 0) begin
                logic [8:0] e;
                e = q_l.pop_front();
                check("lsb_data", 32'(pd_l), 32'(e[7:0]));
                check("lsb_par", 32'(par_l), 32'(e[8]));
            end
        end
        if (done_m) begin
            check("msb_done_expected", 32'(q_m.size() != 0), 32'd1);
            if (q_m.size() != 0) begin
                logic [8:0] e;
                e = q_m.pop_front();
                check("msb_data", 32'(pd_m), 32'(e[7:0]));
                check("msb_par", 32'(par_m), 32'(e[8]));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_bit(input logic b);
        for (int e = 0; e < int'(prescaler); e++) begin
            edge_count  = 6'(e);
            sampled_bit = b;
            tick();
        end
        edge_count = '0;
    endtask

    // stream[i] is the i-th bit on the wire; data_len is disturbed after the first bit
    task automatic run_frame(input logic [3:0] len, input logic [7:0] stream, input int n,
                             input logic [7:0] exp_l, input logic [7:0] exp_m, input logic exp_p);
        q_l.push_back({exp_p, exp_l});
        q_m.push_back({exp_p, exp_m});
        deser_en = 1'b1;
        data_len = len;
        for (int i = 0; i < n; i++) begin
            send_bit(stream[i]);
            if (i == 0) begin
                data_len = 4'd2;
                if (n > 1) check("busy_after_first_bit", 32'(busy_l & busy_m), 32'd1);
            end
        end
        tick();
        tick();
    endtask

    task automatic end_frame();
        deser_en = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] keep_l, keep_m;
        logic       saw_busy;

        RST = 1'b1; deser_en = 1'b0; sampled_bit = 1'b0;
        edge_count = '0; prescaler = 6'd8; data_len = 4'd8;
        tick(); tick();
        check("rst_pd_lsb", 32'(pd_l), 32'd0);
        check("rst_pd_msb", 32'(pd_m), 32'd0);
        check("rst_done_par_busy", 32'({done_l, par_l, busy_l, done_m, par_m, busy_m}), 32'd0);
        RST = 1'b0;
        tick();

        // 8-bit frame, both bit orders
        run_frame(4'd8, 8'h4D, 8, 8'h4D, 8'hB2, 1'b0);
        end_frame();

        // 5-bit frame, then strobes in HOLD must be ignored
        run_frame(4'd5, 8'h1F, 5, 8'h1F, 8'h1F, 1'b1);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        check("hold_pd_lsb", 32'(pd_l), 32'h1F);
        check("hold_pd_msb", 32'(pd_m), 32'h1F);
        check("hold_par", 32'({par_l, par_m}), 32'b11);
        check("hold_busy", 32'({busy_l, busy_m}), 32'd0);
        end_frame();

        // abort after 3 bits keeps the partial word, no done
        deser_en = 1'b1; data_len = 4'd8;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        end_frame();
        tick();
        check("abort_pd_lsb", 32'(pd_l), 32'h05);
        check("abort_pd_msb", 32'(pd_m), 32'hA0);
        check("abort_busy", 32'({busy_l, busy_m}), 32'd0);
        run_frame(4'd8, 8'hA5, 8, 8'hA5, 8'hA5, 1'b0);
        end_frame();

        // short frame after all-ones frame: upper bits cleared
        run_frame(4'd8, 8'hFF, 8, 8'hFF, 8'hFF, 1'b0);
        end_frame();
        run_frame(4'd3, 8'h01, 3, 8'h01, 8'h04, 1'b1);
        end_frame();

        // single-bit frame and clamp of data_len=0 to full width
        run_frame(4'd1, 8'h01, 1, 8'h01, 8'h01, 1'b1);
        end_frame();
        run_frame(4'd0, 8'h96, 8, 8'h96, 8'h69, 1'b0);
        end_frame();

        // prescaler 0 and 1 never strobe
        keep_l = pd_l; keep_m = pd_m; saw_busy = 1'b0;
        deser_en = 1'b1; sampled_bit = 1'b1;
        for (int p = 0; p < 2; p++) begin
            prescaler = 6'(p);
            for (int e = 0; e < 64; e++) begin
                edge_count = 6'(e);
                tick();
                saw_busy = saw_busy | busy_l | busy_m;
            end
        end
        edge_count = '0; prescaler = 6'd8;
        check("nostrobe_busy", 32'(saw_busy), 32'd0);
        check("nostrobe_pd_lsb", 32'(pd_l), 32'(keep_l));
        check("nostrobe_pd_msb", 32'(pd_m), 32'(keep_m));
        end_frame();

        // reset during bit 4 clears everything, then a normal frame
        deser_en = 1'b1; data_len = 4'd8;
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        edge_count = 6'd3; sampled_bit = 1'b1;
        tick();
        RST = 1'b1;
        tick();
        check("rstmid_pd", 32'({pd_l, pd_m}), 32'd0);
        check("rstmid_flags", 32'({done_l, par_l, busy_l, done_m, par_m, busy_m}), 32'd0);
        RST = 1'b0; edge_count = '0;
        end_frame();
        run_frame(4'd8, 8'h4D, 8, 8'h4D, 8'hB2, 1'b0);
        end_frame();

        tick(); tick();
        check("lsb_queue_drained", 32'(q_l.size()), 32'd0);
        check("msb_queue_drained", 32'(q_m.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
